// File: rtl/arith_pkg.sv
// Shared sizing constants and types for the arith_unit_32 block.
// Everything in the unit is sized from these.
package arith_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;

    typedef logic [5:0] ctr_t;

endpackage

// File: rtl/divider_32.sv
// Restoring divider, dividend MSB first.
// A zero divisor naturally yields an all-ones quotient with remainder equal to the dividend.
module divider_32
    import arith_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             finished
);

    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] diff;
    logic             sub_cout;
    logic             no_borrow;
    ctr_t             count;
    logic             done;

    assign shifted = {rem[WIDTH-2:0], quo[WIDTH-1]};

    full_adder_32 u_sub (
        .a   (shifted),
        .b   (~divisor),
        .cin (1'b1),
        .sum (diff),
        .cout(sub_cout)
    );

    // The bit shifted out of rem is the 33rd bit of the trial value; if set, the subtract cannot borrow.
    assign no_borrow = rem[WIDTH-1] | sub_cout;

    always_ff @(posedge clk) begin
        if (reset) begin
            divisor <= b;
            rem     <= '0;
            quo     <= a;
            count   <= '0;
            done    <= 1'b0;
        end else if (!done) begin
            rem   <= no_borrow ? diff : shifted;
            quo   <= {quo[WIDTH-2:0], no_borrow};
            count <= count + 1'b1;
            if (count == ctr_t'(ITERS - 1))
                done <= 1'b1;
        end
    end

    assign quotient  = done ? quo : '0;
    assign remainder = done ? rem : '0;
    assign finished  = done;

endmodule

// File: rtl/full_adder_32.sv
// Unsigned ripple-carry adder.
// Shared by the external adder, the multiplier accumulate and the divider trial-subtract.
module full_adder_32
    import arith_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic carry;

    // The carry is a procedural variable, so the ripple does not form a combinational loop on a vector.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/multiplier_32.sv
// Radix-2 shift-add multiplier.
// Operands load while reset is high; the product is valid after ITERS run cycles.
module multiplier_32
    import arith_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             finished
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_sum;
    logic             acc_cout;
    ctr_t             count;
    logic             done;

    assign addend = acc_lo[0] ? mcand : '0;

    full_adder_32 u_acc (
        .a   (acc_hi),
        .b   (addend),
        .cin (1'b0),
        .sum (acc_sum),
        .cout(acc_cout)
    );

    // acc_lo starts as the multiplier and is shifted out LSB first while product bits shift in.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            count  <= '0;
            done   <= 1'b0;
        end else if (!done) begin
            acc_hi <= {acc_cout, acc_sum[WIDTH-1:1]};
            acc_lo <= {acc_sum[0], acc_lo[WIDTH-1:1]};
            count  <= count + 1'b1;
            if (count == ctr_t'(ITERS - 1))
                done <= 1'b1;
        end
    end

    // Gating keeps the outputs at zero while loading and during the run.
    assign prod_hi  = done ? acc_hi : '0;
    assign prod_lo  = done ? acc_lo : '0;
    assign finished = done;

endmodule

// File: rtl/arith_unit_32.sv
// 32-bit unsigned arithmetic unit: combinational adder plus iterative multiplier and divider.
// reset doubles as operand load and start for both engines.
module arith_unit_32
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             mul_finished,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_finished
);

    full_adder_32 u_add (
        .a   (a),
        .b   (b),
        .cin (cin),
        .sum (sum),
        .cout(cout)
    );

    multiplier_32 u_mul (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo),
        .finished(mul_finished)
    );

    divider_32 u_div (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .quotient (quotient),
        .remainder(remainder),
        .finished (div_finished)
    );

endmodule

// File: tb/tb_arith_unit_32.sv
// Randomized self-checking bench for arith_unit_32 against a plain-arithmetic reference model.
// Inputs change #1 after a rising edge; outputs are sampled there too.
module tb_arith_unit_32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;
    logic        mul_finished;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_finished;

    int checks = 0;
    int errors = 0;

    arith_unit_32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sum         (sum),
        .cout        (cout),
        .prod_hi     (prod_hi),
        .prod_lo     (prod_lo),
        .mul_finished(mul_finished),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_finished(div_finished)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Combinational adder check against 33-bit arithmetic.
    task automatic checkAdder(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
        logic [32:0] exp;
        a   = ta;
        b   = tb;
        cin = tc;
        #1;
        exp = {1'b0, ta} + {1'b0, tb} + {32'b0, tc};
        checkOutput("adder", {31'b0, cout, sum}, {31'b0, exp});
    endtask

    // Load operands with reset high for n edges, then release and scramble the inputs.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input int n);
        reset = 1'b1;
        a     = ta;
        b     = tb;
        repeat (n) @(posedge clk);
        #1;
        checkOutput("reset_flags", {62'b0, mul_finished, div_finished}, 64'd0);
        checkOutput("reset_prod", {prod_hi, prod_lo}, 64'd0);
        checkOutput("reset_div", {quotient, remainder}, 64'd0);
        reset = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Run 32 edges and compare against the model, then confirm the results hold.
    task automatic runAndCheck(input logic [31:0] ea, input logic [31:0] eb);
        logic [63:0] exp_prod;
        logic [31:0] exp_quo;
        logic [31:0] exp_rem;
        exp_prod = {32'b0, ea} * {32'b0, eb};
        exp_quo  = (eb == 0) ? 32'hFFFF_FFFF : ea / eb;
        exp_rem  = (eb == 0) ? ea : ea % eb;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            a = $urandom;
            b = $urandom;
            if (k < 32)
                checkOutput("run_flags", {62'b0, mul_finished, div_finished}, 64'd0);
        end
        checkOutput("done_flags", {62'b0, mul_finished, div_finished}, 64'd3);
        checkOutput("product", {prod_hi, prod_lo}, exp_prod);
        checkOutput("quot_rem", {quotient, remainder}, {exp_quo, exp_rem});
        repeat (10) @(posedge clk);
        #1;
        checkOutput("hold_flags", {62'b0, mul_finished, div_finished}, 64'd3);
        checkOutput("hold_prod", {prod_hi, prod_lo}, exp_prod);
        checkOutput("hold_div", {quotient, remainder}, {exp_quo, exp_rem});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        a     = 32'd0;
        b     = 32'd0;
        cin   = 1'b0;

        // Reset held high for several edges keeps everything at zero.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held_reset_flags", {62'b0, mul_finished, div_finished}, 64'd0);
        checkOutput("held_reset_prod", {prod_hi, prod_lo}, 64'd0);

        checkAdder(32'd24, 32'd44, 1'b0);
        checkAdder(32'd56, 32'd44, 1'b0);
        checkAdder(32'hFFFF_FFFF, 32'd1, 1'b0);
        checkAdder(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 20; i++)
            checkAdder($urandom, $urandom, 1'($urandom_range(0, 1)));

        // Multi-cycle reset: the operand on the final reset edge wins.
        @(posedge clk);
        #1;
        reset = 1'b1;
        a     = 32'd24;
        b     = 32'd44;
        @(posedge clk);
        #1;
        applyStimulus(32'd56, 32'd44, 1);
        runAndCheck(32'd56, 32'd44);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        runAndCheck(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        applyStimulus(32'd99, 32'd3, 1);
        runAndCheck(32'd99, 32'd3);
        applyStimulus(32'd100, 32'd7, 1);
        runAndCheck(32'd100, 32'd7);
        applyStimulus(32'd5, 32'd0, 1);
        runAndCheck(32'd5, 32'd0);

        // Abort a run partway through and restart with new operands.
        applyStimulus(32'd99, 32'd3, 1);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(32'd1000, 32'd10, 1);
        runAndCheck(32'd1000, 32'd10);

        // Abort after completion: flags must drop on the reset edge.
        applyStimulus(32'd7, 32'd0, 1);
        runAndCheck(32'd7, 32'd0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 255));
                2: rb = 32'h8000_0000 | $urandom;
                default: rb = (i == 7) ? 32'd0 : ra;
            endcase
            applyStimulus(ra, rb, 1 + (i % 2));
            runAndCheck(ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_unit_32.md
Name: arith_unit_32

Overview:
- 32-bit unsigned integer arithmetic unit for the UMIX datapath.
- Contains a combinational 32-bit adder with carry in/out, an iterative shift-add multiplier producing a 64-bit product, and an iterative restoring divider producing quotient and remainder.
- Multiplier and divider run concurrently on shared operands. Each starts when reset deasserts and flags completion with its own finished bit.

Parameters:
- WIDTH, 32, operand width; all ports scale from it. The only supported value is 32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset; also serves as operand load/start
- a  input  32  operand A; dividend for division
- b  input  32  operand B; divisor for division
- cin  input  1  adder carry-in
- sum  output  32  adder result
- cout  output  1  adder carry-out
- prod_hi  output  32  product bits [63:32]
- prod_lo  output  32  product bits [31:0]
- mul_finished  output  1  product valid
- quotient  output  32  a / b
- remainder  output  32  a % b
- div_finished  output  1  quotient/remainder valid

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Adder: purely combinational, {cout,sum} = a + b + cin, unsigned, 33-bit result. It ignores clk and reset and tracks inputs in the same delta.
- Reset, any edge with reset=1:
  - capture a and b into internal operand registers (the last captured values win);
  - clear the iteration counters;
  - prod_hi, prod_lo, quotient, remainder = 0;
  - mul_finished = div_finished = 0.
- Run, each edge with reset=0 and unit not finished: perform one iteration of each engine. a and b may change freely during the run with no effect.
- Multiplier: radix-2 shift-add on the captured operands, 32 iterations.
  - mul_finished rises on the 32nd rising edge after the last reset=1 edge.
  - On that same edge {prod_hi,prod_lo} = a*b (full unsigned 64-bit).
- Divider: restoring, MSB first, 32 iterations. Each iteration:
  - shift partial remainder left, bringing in the next dividend bit;
  - trial-subtract the divisor;
  - keep the difference and set the quotient bit if no borrow.
  - div_finished rises on the 32nd rising edge after the last reset=1 edge, with quotient and remainder valid.
- Intermediate values: prod_*, quotient and remainder are unspecified until the matching finished flag rises. The bench checks them only when finished=1.
- After finished: the engine stops iterating. Results and finished=1 hold indefinitely until the next reset=1 edge.
- Divide by zero (b=0 captured): completes in the normal 32 cycles with quotient = 32'hFFFF_FFFF and remainder = a. No error flag.
- Reset mid-operation: aborts immediately, reloads operands, clears outputs; the next run restarts from iteration 0.
- Reset held high: the unit stays in the load state with outputs 0.
- Multi-cycle reset: allowed; operands are taken from the final reset=1 edge.

Decomposition:
- Shared package arith_pkg: WIDTH=32, ITERS=32, counter type logic[5:0].
- full_adder_32 is a natural sub-module, built as a ripple or generate chain. It is instantiated for the external adder and reused for the multiplier accumulate and the divider trial-subtract (b inverted, cin=1).
- multiplier_32 and divider_32 are separate sub-modules, each owning its counter and finished flag.

Test Plan:
- Adder:
  - a=24, b=44, cin=0 -> sum=68, cout=0;
  - then a=56 -> sum=100;
  - a=32'hFFFF_FFFF, b=1, cin=0 -> sum=0, cout=1;
  - a=b=32'hFFFF_FFFF, cin=1 -> sum=32'hFFFF_FFFF, cout=1.
- Multiply:
  - setup: reset=1 with a=24 for one edge, then a=56 on the next edge, b=44; reset=0 from 20 ns, 10 ns clock;
  - during the run: mul_finished=0;
  - after 32 edges: mul_finished=1, prod_hi=0, prod_lo=2464;
  - values still held 10 edges later.
- Multiply, max operands: a=b=32'hFFFF_FFFF -> prod_hi=32'hFFFF_FFFE, prod_lo=1 at edge 32.
- Divide:
  - a=99, b=3, reset one cycle, then released;
  - div_finished rises at edge 32 with quotient=33, remainder=0;
  - a=100, b=7 -> 14 r 2;
  - a=5, b=0 -> quotient=32'hFFFF_FFFF, remainder=5.
- Reset mid-run: start a=99, b=3; at edge 10 assert reset with a=1000, b=10 -> both finished flags drop to 0; after 32 edges quotient=100, remainder=0, prod_lo=10000.
- Operand change during run: change a and b after reset deasserts -> results still reflect the captured operands.
